i281_data_memory: RTL and testbench
===================================

// Module: i281_data_memory
// PURPOSE
//   Writable 16x8 data memory for the i281 CPU, directly downstream of User_Data.
//   After reset, or on request, it copies the 16 assembler-generated initial bytes (b0I..b15I) into its register array.
//   It then serves one synchronous read port and one write port to the CPU datapath (LOAD/STORE).
//   busy tells the control unit when the memory is not yet usable.
// PARAMETERS
//   WIDTH   8   data word width in bits
//   DEPTH   16  number of words; must equal the number of User_Data outputs
//   ADDR_W  4   address width, clog2(DEPTH)
// PORTS
//   clk        in   1      system clock; all state changes on the rising edge
//   rst_n      in   1      asynchronous active-low reset
//   b0I..b15I  in   8 ea.  initial word values; connect straight to User_Data outputs
//   reload     in   1      one-cycle request to re-run the initial copy
//   rd_addr    in   4      read address
//   rd_data    out  8      read data, registered
//   wr_en      in   1      write strobe
//   wr_addr    in   4      write address
//   wr_data    in   8      write data
//   busy       out  1      high while the initial copy runs; CPU must stall
//   wr_dropped out  1      one-cycle pulse when a write is ignored because busy=1
// BEHAVIOUR
//   - Reset (async, rst_n=0): all mem words=0, rd_data=0, wr_dropped=0, idx=0, state=INIT, busy=1.
//   - FSM states INIT and READY. busy = (state==INIT), decoded from registered state.
//   - INIT: each edge does mem[idx] <= bI[idx] and idx <= idx+1.
//     - When idx==DEPTH-1, the next state is READY and idx wraps to 0.
//     - The copy takes exactly 16 edges after rst_n rises; busy is low from edge 16 on.
//   - READY: reload=1 -> INIT, idx=0 at the next edge.
//     - reload while already in INIT restarts the copy at idx=0; words already copied are rewritten.
//   - Write: honoured only in READY with wr_en=1; mem[wr_addr] <= wr_data.
//     - In INIT, wr_en=1 causes no array change and a wr_dropped pulse on the next edge.
//     - reload and wr_en in the same READY cycle: reload wins, the write is dropped and wr_dropped pulses.
//   - Read: rd_data <= mem[rd_addr] every edge, in both states. Latency is 1 cycle.
//     - A read and write to the same address in one cycle returns the OLD value (read-before-write).
//     - The new value is visible one cycle later.
//   - Addresses are full-width; all 16 values are valid, so there is no out-of-range case.
//   - rst_n asserted mid-copy or mid-operation clears everything immediately. The copy restarts from idx=0 on release.
//   - bI inputs are sampled only during INIT; changes to them in READY have no effect until reload.
// STRUCTURE
//   - Shared package i281_pkg: I281_WIDTH=8, I281_DEPTH=16, I281_ADDR_W=4, and the dmem state encoding (INIT=1'b0, READY=1'b1).
//   - The 16 bI inputs are muxed by idx inside this block. The mux is a case statement, not a sub-module.
//   - One natural sub-module: i281_init_sequencer. It holds state, idx, busy and the reload handling, and outputs copy_en and copy_idx.
//   - The array and the read/write logic stay in the top module.
// TESTING
//   1. Reset release with bI = {FE,03,04,01,03,0 x11}.
//      -> busy=1 for 16 edges, then busy=0.
//      -> Reading addr 0..4 gives FE,03,04,01,03; addr 5..15 give 00.
//   2. After init: write addr 2 = 0x7A; same cycle read addr 2.
//      -> rd_data=04 on the next edge, 7A one cycle later.
//   3. wr_en=1 at addr 0 with 0x55 on the 3rd cycle after reset release.
//      -> wr_dropped pulses once; addr 0 reads FE after init.
//   4. READY with mem[1] overwritten to 0x99; pulse reload.
//      -> busy=1 for 16 edges; afterwards addr 1 reads 03.
//   5. Pulse reload again at idx=8 mid-copy.
//      -> Copy restarts; busy stays high 16 edges after the second reload.
//   6. Assert rst_n low mid-INIT with idx=5.
//      -> rd_data=0, busy=1 and all words 0 immediately; the full 16-edge copy runs after release.

Source files
------------

// File: rtl/i281_pkg.sv
// Shared i281 constants and the data-memory state encoding.
package i281_pkg;

  localparam int I281_WIDTH  = 8;
  localparam int I281_DEPTH  = 16;
  localparam int I281_ADDR_W = 4;

  typedef enum logic {
    DMEM_INIT  = 1'b0,
    DMEM_READY = 1'b1
  } dmem_state_e;

endpackage

// File: rtl/i281_init_sequencer.sv
// Walks idx through every word after reset or a reload request, and holds
// busy high until the last initial word has been copied.
module i281_init_sequencer
  import i281_pkg::*;
#(
  parameter int DEPTH  = I281_DEPTH,
  parameter int ADDR_W = I281_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reload,
  output logic              copy_en,
  output logic [ADDR_W-1:0] copy_idx,
  output logic              busy
);

  dmem_state_e       state;
  logic [ADDR_W-1:0] idx;

  // Copy sequencing: a reload in either state restarts the walk at word 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DMEM_INIT;
      idx   <= '0;
    end else begin
      case (state)
        DMEM_INIT: begin
          if (reload) begin
            idx <= '0;
          end else if (idx == ADDR_W'(DEPTH - 1)) begin
            state <= DMEM_READY;
            idx   <= '0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: begin
          if (reload) begin
            state <= DMEM_INIT;
            idx   <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = (state == DMEM_INIT);
  assign copy_en  = busy;
  assign copy_idx = idx;

endmodule

// File: rtl/i281_data_memory.sv
// 16x8 writable data memory for the i281 CPU. Loads its initial image from
// the User_Data outputs, then serves one registered read and one write port.
module i281_data_memory
  import i281_pkg::*;
#(
  parameter int WIDTH  = I281_WIDTH,
  parameter int DEPTH  = I281_DEPTH,
  parameter int ADDR_W = I281_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  b0I,
  input  logic [WIDTH-1:0]  b1I,
  input  logic [WIDTH-1:0]  b2I,
  input  logic [WIDTH-1:0]  b3I,
  input  logic [WIDTH-1:0]  b4I,
  input  logic [WIDTH-1:0]  b5I,
  input  logic [WIDTH-1:0]  b6I,
  input  logic [WIDTH-1:0]  b7I,
  input  logic [WIDTH-1:0]  b8I,
  input  logic [WIDTH-1:0]  b9I,
  input  logic [WIDTH-1:0]  b10I,
  input  logic [WIDTH-1:0]  b11I,
  input  logic [WIDTH-1:0]  b12I,
  input  logic [WIDTH-1:0]  b13I,
  input  logic [WIDTH-1:0]  b14I,
  input  logic [WIDTH-1:0]  b15I,
  input  logic              reload,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              busy,
  output logic              wr_dropped
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic                        copy_en;
  logic [ADDR_W-1:0]           copy_idx;
  logic [WIDTH-1:0]            init_word;

  i281_init_sequencer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .reload   (reload),
    .copy_en  (copy_en),
    .copy_idx (copy_idx),
    .busy     (busy)
  );

  // Select the initial word for the slot currently being copied.
  always_comb begin
    init_word = '0;
    case (copy_idx)
      4'd0:  init_word = b0I;
      4'd1:  init_word = b1I;
      4'd2:  init_word = b2I;
      4'd3:  init_word = b3I;
      4'd4:  init_word = b4I;
      4'd5:  init_word = b5I;
      4'd6:  init_word = b6I;
      4'd7:  init_word = b7I;
      4'd8:  init_word = b8I;
      4'd9:  init_word = b9I;
      4'd10: init_word = b10I;
      4'd11: init_word = b11I;
      4'd12: init_word = b12I;
      4'd13: init_word = b13I;
      4'd14: init_word = b14I;
      4'd15: init_word = b15I;
      default: init_word = '0;
    endcase
  end

  // Array update and registered read. The read samples the array before this
  // edge's write lands, so same-address read/write returns the old word.
  // A reload in READY takes priority over a simultaneous write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem        <= '0;
      rd_data    <= '0;
      wr_dropped <= 1'b0;
    end else begin
      rd_data    <= mem[rd_addr];
      wr_dropped <= wr_en & (busy | reload);
      if (copy_en)
        mem[copy_idx] <= init_word;
      else if (wr_en && !reload)
        mem[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_i281_data_memory.sv
// Directed bench for i281_data_memory with a countdown-based reference model.
module tb_i281_data_memory;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] b [16];
  logic       reload = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [7:0] wr_data = '0;
  logic       busy;
  logic       wr_dropped;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  // reference model
  logic [7:0] mm [16];
  int         remain = 16;
  logic [7:0] exp_rd = '0;
  logic       exp_drop = 1'b0;

  logic [7:0] init_img [16];

  always #5 clk = ~clk;

  i281_data_memory dut (
    .clk(clk), .rst_n(rst_n),
    .b0I(b[0]),   .b1I(b[1]),   .b2I(b[2]),   .b3I(b[3]),
    .b4I(b[4]),   .b5I(b[5]),   .b6I(b[6]),   .b7I(b[7]),
    .b8I(b[8]),   .b9I(b[9]),   .b10I(b[10]), .b11I(b[11]),
    .b12I(b[12]), .b13I(b[13]), .b14I(b[14]), .b15I(b[15]),
    .reload(reload), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .wr_dropped(wr_dropped)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remain counts copy edges still owed; the copy position is 16-remain.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mm[i] = '0;
      remain   = 16;
      exp_rd   = '0;
      exp_drop = 1'b0;
    end else begin
      exp_rd   = mm[rd_addr];
      exp_drop = 1'b0;
      if (remain > 0) begin
        mm[16 - remain] = b[16 - remain];
        remain = reload ? 16 : remain - 1;
        if (wr_en) exp_drop = 1'b1;
      end else if (reload) begin
        remain = 16;
        if (wr_en) exp_drop = 1'b1;
      end else if (wr_en) begin
        mm[wr_addr] = wr_data;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (chk_on) begin
      chk("model_busy", busy, (remain > 0) ? 1 : 0);
      chk("model_rd_data", rd_data, exp_rd);
      chk("model_wr_dropped", wr_dropped, exp_drop);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Cycles from now until busy drops, bounded.
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 40) begin
      cyc();
      n++;
    end
  endtask

  int n;
  int drops;

  initial begin
    init_img = '{8'hFE, 8'h03, 8'h04, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 16; i++) b[i] = init_img[i];
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("reset_busy", busy, 1);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_wr_dropped", wr_dropped, 0);
    chk_on = 1'b1;

    // 1: initial copy after reset release
    rst_n = 1'b1;
    busy_len(n);
    chk("t1_busy_edges", n, 16);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      cyc();
      chk("t1_read_init", rd_data, init_img[a]);
    end

    // 2: read-before-write at the same address
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 8'h7A; rd_addr = 4'd2;
    cyc();
    wr_en = 1'b0;
    chk("t2_old_value", rd_data, 8'h04);
    cyc();
    chk("t2_new_value", rd_data, 8'h7A);

    // input changes in READY are ignored
    b[4] = 8'hAA; rd_addr = 4'd4;
    cyc();
    chk("ready_ignores_bI", rd_data, 8'h03);
    b[4] = 8'h03;

    // 3: write during INIT is dropped
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    cyc();
    cyc();
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h55;
    cyc();
    wr_en = 1'b0;
    drops = wr_dropped ? 1 : 0;
    while (busy && n < 60) begin
      cyc();
      n++;
      if (wr_dropped) drops++;
    end
    chk("t3_drop_pulses", drops, 1);
    rd_addr = 4'd0;
    cyc();
    chk("t3_addr0_kept", rd_data, 8'hFE);

    // 4: reload restores an overwritten word; reload beats a same-cycle write
    wr_en = 1'b1; wr_addr = 4'd1; wr_data = 8'h99;
    cyc();
    wr_en = 1'b0; rd_addr = 4'd1;
    cyc();
    chk("t4_overwritten", rd_data, 8'h99);
    reload = 1'b1; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'h11;
    cyc();
    reload = 1'b0; wr_en = 1'b0;
    chk("t4_reload_drop", wr_dropped, 1);
    busy_len(n);
    chk("t4_busy_edges", n, 16);
    rd_addr = 4'd1;
    cyc();
    chk("t4_addr1_restored", rd_data, 8'h03);
    rd_addr = 4'd3;
    cyc();
    chk("t4_addr3_unwritten", rd_data, 8'h01);

    // 5: reload mid-copy at idx 8 restarts the walk
    reload = 1'b1;
    cyc();
    reload = 1'b0;
    repeat (8) cyc();
    chk("t5_busy_mid", busy, 1);
    reload = 1'b1;
    cyc();
    reload = 1'b0;
    busy_len(n);
    chk("t5_busy_edges", n, 16);

    // 6: async reset mid-copy at idx 5
    reload = 1'b1;
    cyc();
    reload = 1'b0;
    repeat (5) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_rd_data", rd_data, 0);
    chk("t6_async_busy", busy, 1);
    cyc();
    rst_n = 1'b1;
    busy_len(n);
    chk("t6_busy_edges", n, 16);
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      cyc();
      chk("t6_read_init", rd_data, init_img[a]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
